// File: rtl/mem_io_responder.sv
// Memory-side responder: byte RAM plus an I/O window holding a TX FIFO, an RX FIFO,
// a status register and a sticky halt flag. Reads return one cycle after the request.
module mem_io_responder #(
    parameter int RAM_AW  = 17,
    parameter int FIFO_AW = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ma_addr_in,
    input  logic [7:0]  ma_data_in,
    input  logic        ma_rw_in,
    input  logic        ma_ce_in,
    output logic [7:0]  ma_data_out,
    output logic        rdy_out,
    output logic [7:0]  tx_data_out,
    output logic        tx_valid_out,
    input  logic        tx_ready_in,
    input  logic [7:0]  rx_data_in,
    input  logic        rx_valid_in,
    output logic        rx_ready_out,
    output logic        halt_out
);
    localparam int               DEPTH     = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] DEPTH_C   = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0] RDY_LIM_C = (FIFO_AW + 1)'(DEPTH - 1);
    localparam logic [FIFO_AW:0] CNT_ONE_C = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE_C = FIFO_AW'(1);

    logic [7:0] ram_q    [2**RAM_AW];
    logic [7:0] tx_mem_q [DEPTH];
    logic [7:0] rx_mem_q [DEPTH];

    logic [FIFO_AW-1:0] tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
    logic [FIFO_AW-1:0] rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
    logic [FIFO_AW:0]   tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic               overflow_q, overflow_d;
    logic               halt_q, halt_d;
    logic [7:0]         io_rd_q, io_rd_d;
    logic               rd_sel_ram_q, rd_sel_ram_d;
    logic [7:0]         ram_rd_q;

    logic               acc_s, io_sel_s, tx_full_s, rx_nonempty_s;
    logic [3:0]         io_off_s;
    logic [RAM_AW-1:0]  ram_idx_s;
    logic               tx_push_s, tx_drop_s, tx_pop_s, rx_push_s, rx_pop_s;
    logic               status_rd_s, halt_set_s, ram_wr_s, ram_rd_s;
    logic [7:0]         status_s;
    logic               addr_unused;

    // Access decode; an access presented while in reset has no effect
    assign acc_s         = ma_ce_in & ~rst;
    assign io_sel_s      = (ma_addr_in[17:16] == 2'b11);
    assign io_off_s      = ma_addr_in[3:0];
    assign ram_idx_s     = ma_addr_in[RAM_AW-1:0];
    assign addr_unused   = ^ma_addr_in;
    assign tx_full_s     = (tx_cnt_q == DEPTH_C);
    assign rx_nonempty_s = (rx_cnt_q != {(FIFO_AW + 1){1'b0}});
    assign status_s      = {5'b00000, overflow_q, tx_full_s, rx_nonempty_s};

    assign tx_push_s   = acc_s & ma_rw_in & io_sel_s & (io_off_s == 4'h0) & ~tx_full_s;
    assign tx_drop_s   = acc_s & ma_rw_in & io_sel_s & (io_off_s == 4'h0) & tx_full_s;
    assign halt_set_s  = acc_s & ma_rw_in & io_sel_s & (io_off_s == 4'h8);
    assign rx_pop_s    = acc_s & ~ma_rw_in & io_sel_s & (io_off_s == 4'h0) & rx_nonempty_s;
    assign status_rd_s = acc_s & ~ma_rw_in & io_sel_s & (io_off_s == 4'h4);
    assign ram_wr_s    = acc_s & ma_rw_in & ~io_sel_s;
    assign ram_rd_s    = acc_s & ~ma_rw_in & ~io_sel_s;
    assign tx_pop_s    = tx_valid_out & tx_ready_in;
    assign rx_push_s   = rx_valid_in & rx_ready_out & ~rst;

    assign tx_valid_out = (tx_cnt_q != {(FIFO_AW + 1){1'b0}});
    assign tx_data_out  = tx_mem_q[tx_rd_ptr_q];
    assign rx_ready_out = (rx_cnt_q != DEPTH_C);
    assign rdy_out      = (tx_cnt_q < RDY_LIM_C);
    assign halt_out     = halt_q;
    assign ma_data_out  = rd_sel_ram_q ? ram_rd_q : io_rd_q;

    // Next-state for FIFO pointers/counts, flags and the I/O read byte
    always_comb begin
        tx_wr_ptr_d  = tx_wr_ptr_q;
        tx_rd_ptr_d  = tx_rd_ptr_q;
        rx_wr_ptr_d  = rx_wr_ptr_q;
        rx_rd_ptr_d  = rx_rd_ptr_q;
        tx_cnt_d     = tx_cnt_q;
        rx_cnt_d     = rx_cnt_q;
        overflow_d   = overflow_q;
        halt_d       = halt_q;
        io_rd_d      = io_rd_q;
        rd_sel_ram_d = rd_sel_ram_q;

        if (tx_push_s) begin
            tx_wr_ptr_d = tx_wr_ptr_q + PTR_ONE_C;
        end else begin
            tx_wr_ptr_d = tx_wr_ptr_q;
        end
        if (tx_pop_s) begin
            tx_rd_ptr_d = tx_rd_ptr_q + PTR_ONE_C;
        end else begin
            tx_rd_ptr_d = tx_rd_ptr_q;
        end
        case ({tx_push_s, tx_pop_s})
            2'b10:   tx_cnt_d = tx_cnt_q + CNT_ONE_C;
            2'b01:   tx_cnt_d = tx_cnt_q - CNT_ONE_C;
            default: tx_cnt_d = tx_cnt_q;
        endcase

        if (rx_push_s) begin
            rx_wr_ptr_d = rx_wr_ptr_q + PTR_ONE_C;
        end else begin
            rx_wr_ptr_d = rx_wr_ptr_q;
        end
        if (rx_pop_s) begin
            rx_rd_ptr_d = rx_rd_ptr_q + PTR_ONE_C;
        end else begin
            rx_rd_ptr_d = rx_rd_ptr_q;
        end
        case ({rx_push_s, rx_pop_s})
            2'b10:   rx_cnt_d = rx_cnt_q + CNT_ONE_C;
            2'b01:   rx_cnt_d = rx_cnt_q - CNT_ONE_C;
            default: rx_cnt_d = rx_cnt_q;
        endcase

        // A drop and a status read never share a cycle: one access per cycle
        if (tx_drop_s) begin
            overflow_d = 1'b1;
        end else if (status_rd_s) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end

        if (halt_set_s) begin
            halt_d = 1'b1;
        end else begin
            halt_d = halt_q;
        end

        if (acc_s && !ma_rw_in) begin
            rd_sel_ram_d = ~io_sel_s;
            if (io_sel_s) begin
                case (io_off_s)
                    4'h0:    io_rd_d = rx_nonempty_s ? rx_mem_q[rx_rd_ptr_q] : 8'h00;
                    4'h4:    io_rd_d = status_s;
                    default: io_rd_d = 8'h00;
                endcase
            end else begin
                io_rd_d = io_rd_q;
            end
        end else begin
            rd_sel_ram_d = rd_sel_ram_q;
            io_rd_d      = io_rd_q;
        end
    end

    // Control state register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_wr_ptr_q  <= {FIFO_AW{1'b0}};
            tx_rd_ptr_q  <= {FIFO_AW{1'b0}};
            rx_wr_ptr_q  <= {FIFO_AW{1'b0}};
            rx_rd_ptr_q  <= {FIFO_AW{1'b0}};
            tx_cnt_q     <= {(FIFO_AW + 1){1'b0}};
            rx_cnt_q     <= {(FIFO_AW + 1){1'b0}};
            overflow_q   <= 1'b0;
            halt_q       <= 1'b0;
            io_rd_q      <= 8'h00;
            rd_sel_ram_q <= 1'b0;
        end else begin
            tx_wr_ptr_q  <= tx_wr_ptr_d;
            tx_rd_ptr_q  <= tx_rd_ptr_d;
            rx_wr_ptr_q  <= rx_wr_ptr_d;
            rx_rd_ptr_q  <= rx_rd_ptr_d;
            tx_cnt_q     <= tx_cnt_d;
            rx_cnt_q     <= rx_cnt_d;
            overflow_q   <= overflow_d;
            halt_q       <= halt_d;
            io_rd_q      <= io_rd_d;
            rd_sel_ram_q <= rd_sel_ram_d;
        end
    end

    // Data storage; contents survive reset, only the pointers are cleared
    always_ff @(posedge clk) begin
        if (tx_push_s) begin
            tx_mem_q[tx_wr_ptr_q] <= ma_data_in;
        end
        if (rx_push_s) begin
            rx_mem_q[rx_wr_ptr_q] <= rx_data_in;
        end
        if (ram_wr_s) begin
            ram_q[ram_idx_s] <= ma_data_in;
        end
        if (ram_rd_s) begin
            ram_rd_q <= ram_q[ram_idx_s];
        end
    end

endmodule

// File: tb/tb_mem_io_responder.sv
// Randomized and directed bench for mem_io_responder against a queue-based reference model.
module tb_mem_io_responder;
    localparam int RAM_AW  = 16;
    localparam int FIFO_AW = 3;
    localparam int DEPTH   = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ma_addr_in;
    logic [7:0]  ma_data_in;
    logic        ma_rw_in;
    logic        ma_ce_in;
    logic [7:0]  ma_data_out;
    logic        rdy_out;
    logic [7:0]  tx_data_out;
    logic        tx_valid_out;
    logic        tx_ready_in;
    logic [7:0]  rx_data_in;
    logic        rx_valid_in;
    logic        rx_ready_out;
    logic        halt_out;

    always #5 clk = ~clk;

    mem_io_responder #(.RAM_AW(RAM_AW), .FIFO_AW(FIFO_AW)) dut (
        .clk(clk), .rst(rst),
        .ma_addr_in(ma_addr_in), .ma_data_in(ma_data_in), .ma_rw_in(ma_rw_in), .ma_ce_in(ma_ce_in),
        .ma_data_out(ma_data_out), .rdy_out(rdy_out),
        .tx_data_out(tx_data_out), .tx_valid_out(tx_valid_out), .tx_ready_in(tx_ready_in),
        .rx_data_in(rx_data_in), .rx_valid_in(rx_valid_in), .rx_ready_out(rx_ready_out),
        .halt_out(halt_out)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] ram_m [int];
    logic [7:0] tx_q [$];
    logic [7:0] rx_q [$];
    logic       ovf_m;
    logic       halt_m;
    logic [7:0] rd_m;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic check_all();
        check_val("rdata", {24'h0, ma_data_out}, {24'h0, rd_m});
        check_val("rdy", {31'h0, rdy_out}, {31'h0, tx_q.size() < DEPTH - 1});
        check_val("tx_valid", {31'h0, tx_valid_out}, {31'h0, tx_q.size() > 0});
        if (tx_q.size() > 0) check_val("tx_data", {24'h0, tx_data_out}, {24'h0, tx_q[0]});
        check_val("rx_ready", {31'h0, rx_ready_out}, {31'h0, rx_q.size() < DEPTH});
        check_val("halt", {31'h0, halt_out}, {31'h0, halt_m});
    endtask

    // Apply the currently driven inputs to the model, clock the DUT, then compare.
    task automatic step();
        int         txn    = tx_q.size();
        int         rxn    = rx_q.size();
        bit         txpop  = (txn > 0) && (tx_ready_in == 1'b1);
        bit         rxpush = (rx_valid_in == 1'b1) && (rxn < DEPTH);
        bit         txpush = 1'b0;
        bit         rxpop  = 1'b0;
        logic [7:0] rxin   = rx_data_in;
        if (rst) begin
            tx_q.delete();
            rx_q.delete();
            ovf_m  = 1'b0;
            halt_m = 1'b0;
            rd_m   = 8'h00;
        end else begin
            if (ma_ce_in) begin
                int         idx = int'(ma_addr_in[RAM_AW-1:0]);
                bit         io  = (ma_addr_in[17:16] == 2'b11);
                logic [3:0] off = ma_addr_in[3:0];
                if (ma_rw_in) begin
                    if (!io) ram_m[idx] = ma_data_in;
                    else if (off == 4'h0) begin
                        if (txn == DEPTH) ovf_m = 1'b1;
                        else txpush = 1'b1;
                    end else if (off == 4'h8) halt_m = 1'b1;
                end else begin
                    if (!io) rd_m = ram_m[idx];
                    else if (off == 4'h0) begin
                        if (rxn > 0) begin
                            rd_m  = rx_q[0];
                            rxpop = 1'b1;
                        end else rd_m = 8'h00;
                    end else if (off == 4'h4) begin
                        rd_m  = {5'b0, ovf_m, txn == DEPTH, rxn > 0};
                        ovf_m = 1'b0;
                    end else rd_m = 8'h00;
                end
            end
            if (txpop) void'(tx_q.pop_front());
            if (txpush) tx_q.push_back(ma_data_in);
            if (rxpop) void'(rx_q.pop_front());
            if (rxpush) rx_q.push_back(rxin);
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle();
        ma_ce_in = 1'b0;
        ma_rw_in = 1'b0;
        step();
    endtask

    task automatic wr(input logic [31:0] a, input logic [7:0] d);
        ma_ce_in   = 1'b1;
        ma_rw_in   = 1'b1;
        ma_addr_in = a;
        ma_data_in = d;
        step();
    endtask

    task automatic rd(input logic [31:0] a);
        ma_ce_in   = 1'b1;
        ma_rw_in   = 1'b0;
        ma_addr_in = a;
        ma_data_in = 8'($urandom);
        step();
    endtask

    logic [31:0] ram_addrs [16];

    initial begin
        rst = 1'b1; ma_addr_in = 32'h0; ma_data_in = 8'h0; ma_rw_in = 1'b0; ma_ce_in = 1'b0;
        tx_ready_in = 1'b0; rx_data_in = 8'h0; rx_valid_in = 1'b0;
        @(posedge clk);
        #1;
        step();
        rst = 1'b0;
        check_val("rst_rdata", {24'h0, ma_data_out}, 32'h00);
        check_val("rst_rdy", {31'h0, rdy_out}, 32'h1);
        check_val("rst_txv", {31'h0, tx_valid_out}, 32'h0);
        check_val("rst_rxr", {31'h0, rx_ready_out}, 32'h1);
        check_val("rst_halt", {31'h0, halt_out}, 32'h0);

        // RAM round trip and aliasing of upper address bits
        wr(32'h0000_1234, 8'hA5);
        rd(32'h0000_1234);
        check_val("ram_rt", {24'h0, ma_data_out}, 32'hA5);
        rd(32'h0001_1234);
        check_val("ram_alias", {24'h0, ma_data_out}, 32'hA5);
        wr(32'h0000_0077, 8'h3C);
        check_val("hold_after_wr", {24'h0, ma_data_out}, 32'hA5);
        idle();
        check_val("hold_idle", {24'h0, ma_data_out}, 32'hA5);

        // TX fill with a stalled sink, overflow, status clear, drain in order
        for (int i = 0; i < 9; i++) begin
            wr(32'h0003_0000, 8'(8'h41 + i));
            check_val("rdy_fill", {31'h0, rdy_out}, {31'h0, (i + 1) < 7});
        end
        rd(32'h0003_0004);
        check_val("status_ovf", {24'h0, ma_data_out}, 32'h06);
        rd(32'h0003_0004);
        check_val("status_clr", {24'h0, ma_data_out}, 32'h02);
        tx_ready_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check_val("tx_order", {24'h0, tx_data_out}, 32'h41 + i);
            idle();
        end
        check_val("tx_empty", {31'h0, tx_valid_out}, 32'h0);

        // TX push and sink pop together keep the count
        wr(32'h0003_0000, 8'h55);
        wr(32'h0003_0000, 8'h56);
        check_val("tx_swap", {24'h0, tx_data_out}, 32'h56);
        idle();
        tx_ready_in = 1'b0;

        // RX path
        rx_valid_in = 1'b1; rx_data_in = 8'h10; idle();
        rx_data_in = 8'h20; idle();
        rx_valid_in = 1'b0;
        rd(32'h0003_0004);
        check_val("rx_status", {24'h0, ma_data_out}, 32'h01);
        rd(32'h0003_0000);
        check_val("rx_pop1", {24'h0, ma_data_out}, 32'h10);
        rd(32'h0003_0000);
        check_val("rx_pop2", {24'h0, ma_data_out}, 32'h20);
        rd(32'h0003_0000);
        check_val("rx_empty_rd", {24'h0, ma_data_out}, 32'h00);
        rd(32'h0003_0004);
        check_val("rx_status0", {24'h0, ma_data_out}, 32'h00);
        rd(32'h0003_0008);
        check_val("io_rd8", {24'h0, ma_data_out}, 32'h00);

        // RX push and core pop in the same cycle, near and at full
        rx_valid_in = 1'b1;
        for (int i = 0; i < 7; i++) begin
            rx_data_in = 8'(8'h60 + i);
            idle();
        end
        rx_data_in = 8'h70;
        rd(32'h0003_0000);
        check_val("rx_sim_pop", {24'h0, ma_data_out}, 32'h60);
        rx_data_in = 8'h71; idle();
        check_val("rx_full", {31'h0, rx_ready_out}, 32'h0);
        rx_data_in = 8'h72;
        rd(32'h0003_0000);
        check_val("rx_full_pop", {24'h0, ma_data_out}, 32'h61);
        rx_valid_in = 1'b0;
        for (int i = 0; i < 10; i++) rd(32'h0003_0000);

        // Reset with both FIFOs partly full; the RAM write in the reset cycle is ignored
        for (int i = 0; i < 3; i++) wr(32'h0003_0000, 8'(8'h80 + i));
        rx_valid_in = 1'b1; rx_data_in = 8'h91; idle(); rx_valid_in = 1'b0;
        rd(32'h0000_1234);
        rst = 1'b1;
        wr(32'h0000_1234, 8'hEE);
        rst = 1'b0;
        check_val("rr_rdata", {24'h0, ma_data_out}, 32'h00);
        check_val("rr_rdy", {31'h0, rdy_out}, 32'h1);
        check_val("rr_txv", {31'h0, tx_valid_out}, 32'h0);
        check_val("rr_rxr", {31'h0, rx_ready_out}, 32'h1);
        rd(32'h0003_0004);
        check_val("rr_status", {24'h0, ma_data_out}, 32'h00);
        rd(32'h0000_1234);
        check_val("rr_ram", {24'h0, ma_data_out}, 32'hA5);

        // Randomized traffic
        for (int i = 0; i < 16; i++) begin
            ram_addrs[i] = 32'($urandom_range(0, 65535));
            wr(ram_addrs[i], 8'($urandom));
        end
        for (int c = 0; c < 3000; c++) begin
            logic [31:0] a;
            int          kind = int'($urandom_range(0, 9));
            tx_ready_in = 1'($urandom);
            rx_valid_in = 1'($urandom);
            rx_data_in  = 8'($urandom);
            if (kind < 4) begin
                a        = ram_addrs[$urandom_range(0, 15)];
                a[31:18] = 14'($urandom);
                a[16]    = 1'($urandom);
                if (kind < 2) rd(a);
                else wr(a, 8'($urandom));
            end else if (kind < 9) begin
                a = 32'h0003_0000;
                case ($urandom_range(0, 4))
                    0, 1:    a[3:0] = 4'h0;
                    2:       a[3:0] = 4'h4;
                    3:       a[3:0] = 4'($urandom);
                    default: a[3:0] = ($urandom_range(0, 15) == 0) ? 4'h8 : 4'h0;
                endcase
                if ($urandom_range(0, 1) == 0) rd(a);
                else wr(a, 8'($urandom));
            end else begin
                idle();
            end
        end
        rx_valid_in = 1'b0;
        wr(32'h0003_0008, 8'h01);
        check_val("halt_set", {31'h0, halt_out}, 32'h1);
        idle(); idle();
        check_val("halt_sticky", {31'h0, halt_out}, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
